register_file_param: RTL and testbench

Parametrised multi-entry register file built from WIDTH-bit storage words: one synchronous write port with byte enables and two asynchronous read ports. It is the generalised successor to the fixed-width register primitives and backs the decode stage's architectural register set. A compile-time write-to-read bypass lets a same-cycle read see the data being written.

---
 rtl/register_file_param.sv | 118 +++++++++++
 tb/tb_register_file_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// register_file_param
//   Parametrised register file: DEPTH words of WIDTH bits, one synchronous
//   byte-enabled write port and two independent asynchronous read ports.
//
// Parameters
//   WIDTH    data width, multiple of 8
//   DEPTH    number of entries, >= 2, need not be a power of two
//   AW       address width, 2**AW >= DEPTH
//   ZERO_REG 1: entry 0 always reads zero and ignores writes
//
// Ports
//   clk                    rising-edge clock
//   rst                    synchronous active-low reset (clears storage and err)
//   write                  write request
//   writeaddr / writedata  write address / data
//   byteen                 per-byte write enable, bit i -> writedata[8i+7:8i]
//   readaddr0/1            read addresses
//   readdata0/1            read data (zero for out-of-range or hard-wired entry 0)
//   err                    sticky: a write to an address >= DEPTH was seen
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read of the entry being written in the
//                      same cycle returns the merged (post-write) word.

module register_file_param #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AW       = 3,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write,
    input  logic [AW-1:0]      writeaddr,
    input  logic [WIDTH-1:0]   writedata,
    input  logic [WIDTH/8-1:0] byteen,
    input  logic [AW-1:0]      readaddr0,
    input  logic [AW-1:0]      readaddr1,
    output logic [WIDTH-1:0]   readdata0,
    output logic [WIDTH-1:0]   readdata1,
    output logic               err
);

    localparam int unsigned NB = WIDTH / 8;
    // DEPTH expressed in AW+1 bits so address range checks are width-matched
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_inrange;
    logic             wr_ok;
    logic             rd0_ok;
    logic             rd1_ok;
    logic [WIDTH-1:0] stored_w;
    logic [WIDTH-1:0] merged;

    always_comb begin
        wr_inrange = ({1'b0, writeaddr} < DEPTH_W);
        wr_ok      = rst && write && wr_inrange && !(ZERO_REG && (writeaddr == '0));
        rd0_ok     = ({1'b0, readaddr0} < DEPTH_W) && !(ZERO_REG && (readaddr0 == '0));
        rd1_ok     = ({1'b0, readaddr1} < DEPTH_W) && !(ZERO_REG && (readaddr1 == '0));
    end

    // Stored word at the write address; only consumed when wr_ok, so the
    // out-of-range case never reaches storage or the read ports.
    always_comb begin
        stored_w = '0;
        if (wr_inrange) begin
            stored_w = mem[writeaddr];
        end
    end

    // Byte-merge of write data over the currently stored word
    for (genvar b = 0; b < NB; b++) begin : g_merge
        always_comb begin
            merged[8*b +: 8] = byteen[b] ? writedata[8*b +: 8] : stored_w[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem <= '{default: '0};
            err <= 1'b0;
        end else begin
            if (write && !wr_inrange) begin
                err <= 1'b1;
            end
            if (wr_ok) begin
                mem[writeaddr] <= merged;
            end
        end
    end

    always_comb begin
        readdata0 = '0;
        if (rd0_ok) begin
            readdata0 = mem[readaddr0];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (readaddr0 == writeaddr)) begin
            readdata0 = merged;
        end
`endif
    end

    always_comb begin
        readdata1 = '0;
        if (rd1_ok) begin
            readdata1 = mem[readaddr1];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (readaddr1 == writeaddr)) begin
            readdata1 = merged;
        end
`endif
    end

endmodule

// File: tb/tb_register_file_param.sv
// Testbench for register_file_param: three instances share the write/read
// inputs -- defaults (DEPTH=8), ZERO_REG=1, and DEPTH=6 -- with expected
// values written out by hand for each directed step.

module tb_register_file_param;

    logic        clk;
    logic        rst;
    logic        write;
    logic [2:0]  writeaddr;
    logic [15:0] writedata;
    logic [1:0]  byteen;
    logic [2:0]  readaddr0;
    logic [2:0]  readaddr1;

    logic [15:0] rd0_a, rd1_a, rd0_z, rd1_z, rd0_s, rd1_s;
    logic        err_a, err_z, err_s;

    int checks   = 0;
    int failures = 0;

    register_file_param u_dut (
        .clk(clk), .rst(rst), .write(write), .writeaddr(writeaddr),
        .writedata(writedata), .byteen(byteen),
        .readaddr0(readaddr0), .readaddr1(readaddr1),
        .readdata0(rd0_a), .readdata1(rd1_a), .err(err_a)
    );

    register_file_param #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(1'b1)) u_zr (
        .clk(clk), .rst(rst), .write(write), .writeaddr(writeaddr),
        .writedata(writedata), .byteen(byteen),
        .readaddr0(readaddr0), .readaddr1(readaddr1),
        .readdata0(rd0_z), .readdata1(rd1_z), .err(err_z)
    );

    register_file_param #(.WIDTH(16), .DEPTH(6), .AW(3), .ZERO_REG(1'b0)) u_d6 (
        .clk(clk), .rst(rst), .write(write), .writeaddr(writeaddr),
        .writedata(writedata), .byteen(byteen),
        .readaddr0(readaddr0), .readaddr1(readaddr1),
        .readdata0(rd0_s), .readdata1(rd1_s), .err(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        write     = 1'b1;
        writeaddr = a;
        writedata = d;
        byteen    = be;
        tick();
        write     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b0; write = 1'b0; writeaddr = '0; writedata = '0; byteen = '0;
        readaddr0 = '0; readaddr1 = '0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        readaddr0 = 3'd5; readaddr1 = 3'd0; #1;
        check("rst_rd0", rd0_a, 0);
        check("rst_rd1", rd1_a, 0);
        check("rst_err_a", err_a, 0);
        check("rst_err_s", err_s, 0);

        // Byte enables
        wr(3'd3, 16'hABCD, 2'b11);
        wr(3'd3, 16'h1234, 2'b01);
        readaddr0 = 3'd3; #1;
        check("be_lo", rd0_a, 16'hAB34);
        wr(3'd3, 16'h5678, 2'b10);
        #1;
        check("be_hi", rd0_a, 16'h5634);
        wr(3'd3, 16'hFFFF, 2'b00);
        #1;
        check("be_none", rd0_a, 16'h5634);
        check("be_none_err", err_a, 0);

        // Dual read sweep
        for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * i), 2'b11);
        for (int i = 0; i < 8; i++) begin
            readaddr0 = 3'(i);
            readaddr1 = 3'(7 - i);
            #1;
            check($sformatf("dual_rd0_%0d", i), rd0_a, 16'(16'h1111 * i));
            check($sformatf("dual_rd1_%0d", i), rd1_a, 16'(16'h1111 * (7 - i)));
        end
        readaddr0 = 3'd4; readaddr1 = 3'd4; #1;
        check("dual_same", rd0_a, rd1_a);
        check("dual_same_val", rd1_a, 16'h4444);

        // Reset with simultaneous write: write dropped, everything cleared
        rst = 1'b0;
        write = 1'b1; writeaddr = 3'd2; writedata = 16'h5A5A; byteen = 2'b11;
        tick();
        rst = 1'b1; write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            readaddr0 = 3'(i); #1;
            check($sformatf("rst_clr_%0d", i), rd0_a, 0);
        end
        check("rst_clr_err", err_a, 0);

        // ZERO_REG
        wr(3'd0, 16'hFFFF, 2'b11);
        wr(3'd1, 16'hFFFF, 2'b11);
        readaddr0 = 3'd0; readaddr1 = 3'd1; #1;
        check("zr_addr0", rd0_z, 16'h0000);
        check("zr_addr1", rd1_z, 16'hFFFF);
        check("nozr_addr0", rd0_a, 16'hFFFF);
        write = 1'b1; writeaddr = 3'd0; writedata = 16'h1234; byteen = 2'b11; #1;
        check("zr_no_bypass", rd0_z, 16'h0000);
        write = 1'b0;

        // Out of range on DEPTH=6
        do_reset();
        for (int i = 0; i < 6; i++) wr(3'(i), 16'(16'h1010 * (i + 1)), 2'b11);
        write = 1'b1; writeaddr = 3'd7; writedata = 16'hBEEF; byteen = 2'b11;
        readaddr0 = 3'd7; #1;
        check("oor_err_before", err_s, 0);
        check("oor_no_bypass", rd0_s, 0);
        tick();
        write = 1'b0;
        check("oor_err_after", err_s, 1);
        check("oor_err_depth8", err_a, 0);
        for (int i = 0; i < 6; i++) begin
            readaddr0 = 3'(i); #1;
            check($sformatf("oor_keep_%0d", i), rd0_s, 16'(16'h1010 * (i + 1)));
        end
        readaddr0 = 3'd7; readaddr1 = 3'd6; #1;
        check("oor_rd7", rd0_s, 0);
        check("oor_rd6", rd1_s, 0);
        tick();
        wr(3'd1, 16'h0F0F, 2'b11);
        check("oor_sticky", err_s, 1);
        do_reset();
        check("oor_err_cleared", err_s, 0);

        // Bypass
        wr(3'd2, 16'hAA00, 2'b11);
        write = 1'b1; writeaddr = 3'd2; writedata = 16'h00FF; byteen = 2'b01;
        readaddr0 = 3'd2; readaddr1 = 3'd3; #1;
`ifdef REGFILE_BYPASS_EN
        v = 16'hAAFF;
`else
        v = 16'hAA00;
`endif
        check("byp_same_cycle", rd0_a, v);
        check("byp_other_port", rd1_a, 0);
        tick();
        write = 1'b0;
        check("byp_after_edge", rd0_a, 16'hAAFF);

        // No bypass while reset is asserted
        rst = 1'b0;
        write = 1'b1; writeaddr = 3'd2; writedata = 16'h1111; byteen = 2'b11; #1;
        check("byp_rst_blocked", rd0_a, 16'hAAFF);
        tick();
        rst = 1'b1; write = 1'b0;
        check("byp_rst_cleared", rd0_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
